// File: rtl/spike_rate_meter.sv
// Spike rate meter: counts rising spike edges per fixed window
// and reports the last inter-spike interval with a one-deep output.
module spike_rate_meter #(
  parameter int WIN_LOG2 = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike,
  input  logic             enable,
  output logic [CNT_W-1:0] rate,
  output logic [CNT_W-1:0] isi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;

  state_t              state_q;
  logic                spike_q;
  logic [WIN_LOG2-1:0] win_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    ivl_q;
  logic [CNT_W-1:0]    isi_q;
  logic                seen_q;
  logic [CNT_W-1:0]    rate_q;
  logic [CNT_W-1:0]    isi_out_q;
  logic                valid_q;
  logic                ovr_q;

  logic             ev;
  logic             counting;
  logic             close;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] ivl_inc;
  logic [CNT_W-1:0] isi_d;

  assign ev       = spike & ~spike_q;
  assign counting = (state_q == COUNT) & enable;
  assign close    = counting & (win_q == '1);

  // Window totals including any event on the current cycle
  always_comb begin
    cnt_d   = cnt_q;
    ivl_inc = MAX;
    isi_d   = isi_q;
    if (ev && cnt_q != MAX) cnt_d = cnt_q + CNT_W'(1);
    if (ivl_q != MAX) ivl_inc = ivl_q + CNT_W'(1);
    if (ev && seen_q) isi_d = ivl_inc;
  end

  // Mode FSM, window/spike/interval counters and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      spike_q   <= 1'b0;
      win_q     <= '0;
      cnt_q     <= '0;
      ivl_q     <= '0;
      isi_q     <= '0;
      seen_q    <= 1'b0;
      rate_q    <= '0;
      isi_out_q <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      spike_q <= spike;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= COUNT;
            win_q   <= '0;
            cnt_q   <= '0;
            ivl_q   <= '0;
            isi_q   <= '0;
            seen_q  <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            win_q <= win_q + WIN_LOG2'(1);
            ivl_q <= ev ? '0 : ivl_inc;
            if (ev) seen_q <= 1'b1;
            if (close) begin
              cnt_q <= '0;
              isi_q <= '0;
            end else begin
              cnt_q <= cnt_d;
              isi_q <= isi_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (close && (!valid_q || out_ready)) begin
        rate_q    <= cnt_d;
        isi_out_q <= isi_d;
        valid_q   <= 1'b1;
      end else if (close) begin
        ovr_q <= 1'b1;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rate      = rate_q;
  assign isi       = isi_out_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spike_rate_meter.sv
// Bench for spike_rate_meter: window vectors, corner sequences
// and a random run checked against a timestamp-based model.
module tb_spike_rate_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sp1, en1, rd1;
  logic [7:0] rate1, isi1;
  logic       v1, ov1;
  logic       sp2, en2, rd2;
  logic [3:0] rate2, isi2;
  logic       v2, ov2;
  logic [7:0] rate3, isi3;
  logic       v3, ov3;

  int checks = 0;
  int errors = 0;

  spike_rate_meter #(.WIN_LOG2(4), .CNT_W(8)) u1 (
    .clk(clk), .reset_n(rst_n), .spike(sp1), .enable(en1),
    .rate(rate1), .isi(isi1), .out_valid(v1),
    .out_ready(rd1), .overrun(ov1)
  );

  spike_rate_meter #(.WIN_LOG2(6), .CNT_W(4)) u2 (
    .clk(clk), .reset_n(rst_n), .spike(sp2), .enable(en2),
    .rate(rate2), .isi(isi2), .out_valid(v2),
    .out_ready(rd2), .overrun(ov2)
  );

  spike_rate_meter u3 (
    .clk(clk), .reset_n(rst_n), .spike(sp2), .enable(en2),
    .rate(rate3), .isi(isi3), .out_valid(v3),
    .out_ready(rd2), .overrun(ov3)
  );

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          rate;
    int          isi;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    sp1 = 1'b0; en1 = 1'b0; rd1 = 1'b1;
    sp2 = 1'b0; en2 = 1'b0; rd2 = 1'b1;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_window(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      sp1 = mask[i];
      tick();
    end
    sp1 = 1'b0;
  endtask

  task automatic start1;
    do_reset();
    en1 = 1'b1;
    tick();
  endtask

  // reference model state
  bit m_run, m_spq, m_valid, m_ov;
  int m_pos, m_cnt, m_last, m_isil, m_rate, m_isi;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input int t);
    bit ev, cl;
    ev = sp1 && !m_spq;
    cl = 1'b0;
    if (!m_run) begin
      if (en1) begin
        m_run = 1'b1; m_pos = 0; m_cnt = 0;
        m_last = -1; m_isil = 0;
      end
    end else if (!en1) begin
      m_run = 1'b0;
    end else begin
      if (ev) begin
        m_cnt++;
        if (m_last >= 0) m_isil = imin(t - m_last, 255);
        m_last = t;
      end
      cl = (m_pos == 15);
      m_pos = (m_pos + 1) % 16;
    end
    if (cl && (!m_valid || rd1)) begin
      m_rate = imin(m_cnt, 255);
      m_isi = m_isil;
      m_valid = 1'b1;
    end else if (cl) begin
      m_ov = 1'b1;
    end else if (m_valid && rd1) begin
      m_valid = 1'b0;
    end
    if (cl) begin
      m_cnt = 0;
      m_isil = 0;
    end
    m_spq = sp1;
  endtask

  initial begin
    int n, k;
    tbl[0] = '{"every4",   16'h1111, 4, 4};
    tbl[1] = '{"none",     16'h0000, 0, 0};
    tbl[2] = '{"close_ev", 16'h8004, 2, 13};
    tbl[3] = '{"single",   16'h0001, 1, 0};
    tbl[4] = '{"held10",   16'h3FF0, 1, 0};
    tbl[5] = '{"alt",      16'hAAAA, 8, 2};
    tbl[6] = '{"ends",     16'h8001, 2, 15};
    tbl[7] = '{"allhigh",  16'hFFFF, 1, 0};

    do_reset();
    chk("rst_rate", rate1, 0);
    chk("rst_isi", isi1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_ovr", ov1, 0);
    chk("rst_valid3", v3, 0);

    for (int r = 0; r < 8; r++) begin
      start1();
      run_window(tbl[r].mask);
      chk({tbl[r].name, "_valid"}, v1, 1);
      chk({tbl[r].name, "_rate"}, rate1, tbl[r].rate);
      chk({tbl[r].name, "_isi"}, isi1, tbl[r].isi);
    end

    // out_valid pulses once per window at steady rate
    start1();
    n = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 16; i++) begin
        sp1 = (i % 4 == 0);
        tick();
        if (v1) begin
          n++;
          chk("pulse_rate", rate1, 4);
          chk("pulse_isi", isi1, 4);
        end
      end
    end
    sp1 = 1'b0;
    chk("pulse_count", n, 3);

    // closing-cycle event, next window starts empty
    start1();
    run_window(16'h8004);
    chk("cl_rate", rate1, 2);
    chk("cl_isi", isi1, 13);
    run_window(16'h0000);
    chk("cl_next_rate", rate1, 0);
    chk("cl_next_isi", isi1, 0);

    // back-pressure across two closes
    start1();
    rd1 = 1'b0;
    run_window(16'h0101);
    chk("ov1_valid", v1, 1);
    chk("ov1_rate", rate1, 2);
    chk("ov1_isi", isi1, 8);
    chk("ov1_ovr", ov1, 0);
    run_window(16'h1111);
    chk("ov2_valid", v1, 1);
    chk("ov2_rate", rate1, 2);
    chk("ov2_isi", isi1, 8);
    chk("ov2_ovr", ov1, 1);
    rd1 = 1'b1;
    tick();
    chk("ov3_valid", v1, 0);
    chk("ov3_ovr", ov1, 1);

    // asynchronous reset mid-window with a pending result
    start1();
    rd1 = 1'b0;
    run_window(16'h0011);
    chk("ar_pre_valid", v1, 1);
    for (int i = 0; i < 5; i++) begin
      sp1 = (i == 2);
      tick();
    end
    sp1 = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_rate", rate1, 0);
    chk("ar_isi", isi1, 0);
    chk("ar_valid", v1, 0);
    chk("ar_ovr", ov1, 0);
    #2;
    rst_n = 1'b1;
    rd1 = 1'b1;
    n = 0;
    while (n < 40) begin
      n++;
      tick();
      if (v1) break;
    end
    chk("ar_latency", n, 17);
    chk("ar_rate2", rate1, 0);

    // rate saturation (4-bit count, 64-cycle window)
    do_reset();
    en2 = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      sp2 = (i % 2 == 0);
      tick();
    end
    sp2 = 1'b0;
    chk("sat_valid", v2, 1);
    chk("sat_rate", rate2, 15);
    chk("sat_isi", isi2, 2);

    // interval saturation with default parameters
    do_reset();
    en2 = 1'b1;
    tick();
    k = 0;
    for (int c = 0; c < 512; c++) begin
      sp2 = (c == 0 || c == 301);
      tick();
      if (v3) begin
        k++;
        if (k == 1) begin
          chk("isat_w0_rate", rate3, 1);
          chk("isat_w0_isi", isi3, 0);
        end else begin
          chk("isat_w1_rate", rate3, 1);
          chk("isat_w1_isi", isi3, 255);
        end
      end
    end
    sp2 = 1'b0;
    chk("isat_results", k, 2);

    // random run against the reference model
    do_reset();
    m_run = 0; m_spq = 0; m_valid = 0; m_ov = 0;
    m_pos = 0; m_cnt = 0; m_last = -1; m_isil = 0;
    m_rate = 0; m_isi = 0;
    for (int t = 0; t < 3000; t++) begin
      en1 = ($urandom_range(99) < 97);
      sp1 = ($urandom_range(99) < 35);
      rd1 = ($urandom_range(99) < 60);
      model_step(t);
      tick();
      chk("rnd_valid", v1, int'(m_valid));
      chk("rnd_ovr", ov1, int'(m_ov));
      chk("rnd_rate", rate1, m_rate);
      chk("rnd_isi", isi1, m_isi);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
